// File: rtl/su_bus_arb_pkg.sv
// Shared types and limits for the setup-unit result-bus arbiter.
package su_bus_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int unsigned NREQ_MAX     = 8;
  localparam int unsigned TURN_CYC_MIN = 1;
  localparam int unsigned TURN_CYC_MAX = 3;
  localparam int unsigned TURN_W       = 2;
  localparam int unsigned MAX_HOLD_DEF = 64;

endpackage

// File: rtl/su_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module su_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot    = N'({req, req} >> ptr);
    rot_oh = rot & (~rot + N'(1));
    winner = N'(({rot_oh, rot_oh} << ptr) >> N);
    valid  = |req;
  end

endmodule

// File: rtl/su_bus_arb.sv
// Round-robin owner sequencer for the shared tri-state result bus with dead cycles.
// Optional hold watchdog: define SU_BUS_ARB_WATCHDOG_EN.
module su_bus_arb
  import su_bus_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] oe,
  output logic            busy,
  output logic            err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TURN_W-1:0] TURN_INIT = TURN_W'(TURN_CYC - 1);

  if (NREQ < 1 || NREQ > NREQ_MAX || TURN_CYC < TURN_CYC_MIN ||
      TURN_CYC > TURN_CYC_MAX || MAX_HOLD < 2) begin : g_param_err
    $error("su_bus_arb: illegal parameter set");
  end

  state_t            state, state_nxt;
  logic [NREQ-1:0]   gnt_q, gnt_nxt, pick;
  logic [PW-1:0]     rr_ptr, ptr_nxt, owner_idx, ptr_after;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;
  logic              pick_valid, normal_end, tenure_end, timeout;

  su_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) owner_idx = PW'(i);
    end
    ptr_after  = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
    // Owner dropping req is an abort and ends the tenure like last does.
    normal_end = ~|(gnt_q & req) | (|(gnt_q & req & last));
    tenure_end = normal_end | timeout;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      gnt_q    <= '0;
      rr_ptr   <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      rr_ptr   <= ptr_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    ptr_nxt   = rr_ptr;
    turn_nxt  = turn_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = pick;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
          turn_nxt  = TURN_INIT;
        end
      end
      TURN: begin
        if (turn_cnt != '0) begin
          turn_nxt = turn_cnt - TURN_W'(1);
        end else if (pick_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = pick;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    gnt  = gnt_q;
    oe   = gnt_q;
    busy = (state != IDLE);
  end

`ifdef SU_BUS_ARB_WATCHDOG_EN
  localparam int unsigned HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_cnt;
  logic          err_q;

  // A coincident normal end wins over the watchdog and does not flag err.
  assign timeout = (state == GRANT) && (hold_cnt == HW'(MAX_HOLD - 1)) && !normal_end;
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT && !tenure_end) ? hold_cnt + HW'(1) : '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_su_bus_arb.sv
// Directed and invariant bench for su_bus_arb; DUT1 uses TURN_CYC=1, DUT2 TURN_CYC=2.
module tb_su_bus_arb;

  localparam int N = 4;

  logic         clk;
  logic         reset_l;
  logic [N-1:0] req, last;
  logic [N-1:0] gnt1, oe1, gnt2, oe2;
  logic         busy1, err1, busy2, err2;

  int           n_cmp;
  int           n_err;
  logic [N-1:0] prev_oe [2];
  int           zrun    [2];
  bit           had     [2];

  su_bus_arb #(.NREQ(N), .TURN_CYC(1), .MAX_HOLD(8)) u_dut1 (
    .clk(clk), .reset_l(reset_l), .req(req), .last(last),
    .gnt(gnt1), .oe(oe1), .busy(busy1), .err(err1)
  );

  su_bus_arb #(.NREQ(N), .TURN_CYC(2), .MAX_HOLD(64)) u_dut2 (
    .clk(clk), .reset_l(reset_l), .req(req), .last(last),
    .gnt(gnt2), .oe(oe2), .busy(busy2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    req     = '0;
    last    = '0;
    tick();
    tick();
    reset_l = 1'b1;
  endtask

  task automatic track(input int idx, input logic [N-1:0] o, input int tc);
    check($sformatf("onehot%0d", idx), 32'($countones(o) <= 1), 32'd1);
    if (o != '0 && o != prev_oe[idx] && had[idx])
      check($sformatf("gap%0d", idx), 32'(zrun[idx] >= tc), 32'd1);
    if (o == '0) begin
      zrun[idx]++;
    end else begin
      zrun[idx] = 0;
      had[idx]  = 1'b1;
    end
    prev_oe[idx] = o;
  endtask

  initial begin
    logic [N-1:0] own;
    n_cmp   = 0;
    n_err   = 0;
    reset_l = 1'b0;
    req     = '0;
    last    = '0;
    tick();
    tick();
    check("rst_gnt1", 32'(gnt1), 32'h0);
    check("rst_oe1", 32'(oe1), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    check("rst_err1", 32'(err1), 32'h0);
    check("rst_gnt2", 32'(gnt2), 32'h0);
    reset_l = 1'b1;

    // Reset in the middle of a grant, with rr_ptr moved away from 0 first.
    req = 4'b0001;
    tick();
    check("mg_grant0", 32'(gnt1), 32'h1);
    last = 4'b0001;
    tick();
    check("mg_end", 32'(gnt1), 32'h0);
    check("mg_turn_busy", 32'(busy1), 32'h1);
    req  = 4'b0010;
    last = '0;
    tick();
    check("mg_grant1", 32'(gnt1), 32'h2);
    tick();
    #2 reset_l = 1'b0;
    #1;
    check("mg_async_gnt", 32'(gnt1), 32'h0);
    check("mg_async_oe", 32'(oe1), 32'h0);
    check("mg_async_busy", 32'(busy1), 32'h0);
    req = 4'b1111;
    tick();
    reset_l = 1'b1;
    tick();
    check("mg_ptr0", 32'(gnt1), 32'h1);

    // Round robin, three-cycle tenures, last from non-owners must be ignored.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      own = 4'(1 << (k % 4));
      for (int c = 0; c < 3; c++) begin
        tick();
        check($sformatf("rr%0d_c%0d_gnt", k, c), 32'(gnt1), 32'(own));
        check($sformatf("rr%0d_c%0d_oe", k, c), 32'(oe1), 32'(own));
        last = (c == 2) ? own : ~own;
      end
      tick();
      last = '0;
      check($sformatf("rr%0d_dead", k), 32'(oe1), 32'h0);
      check($sformatf("rr%0d_busy", k), 32'(busy1), 32'h1);
    end

    // Back-to-back handover straight out of TURN.
    do_reset();
    req = 4'b0011;
    tick();
    check("b2b_g0", 32'(gnt2), 32'h1);
    last = 4'b0001;
    tick();
    check("b2b_dead1", 32'(oe2), 32'h0);
    check("b2b_busy1", 32'(busy2), 32'h1);
    last = '0;
    tick();
    check("b2b_dead2", 32'(oe2), 32'h0);
    check("b2b_busy2", 32'(busy2), 32'h1);
    check("b2b_tc1_g1", 32'(gnt1), 32'h2);
    tick();
    check("b2b_g1", 32'(gnt2), 32'h2);
    check("b2b_busy3", 32'(busy2), 32'h1);
    check("b2b_err2", 32'(err2), 32'h0);

    // Abort, single-cycle tenure, last without req.
    do_reset();
    req = 4'b0100;
    tick();
    check("ab_g", 32'(gnt1), 32'h4);
    tick();
    check("ab_hold", 32'(gnt1), 32'h4);
    req = '0;
    tick();
    check("ab_drop", 32'(oe1), 32'h0);
    tick();
    check("ab_idle", 32'(busy1), 32'h0);
    req  = 4'b0100;
    last = 4'b0100;
    tick();
    check("sc_on", 32'(oe1), 32'h4);
    tick();
    check("sc_off", 32'(oe1), 32'h0);
    req  = '0;
    last = '0;
    tick();
    check("sc_idle_oe", 32'(oe1), 32'h0);
    check("sc_idle_busy", 32'(busy1), 32'h0);
    last = 4'b1111;
    tick();
    check("lastonly_gnt", 32'(gnt1), 32'h0);
    check("lastonly_busy", 32'(busy1), 32'h0);
    last = '0;

`ifdef SU_BUS_ARB_WATCHDOG_EN
    do_reset();
    req = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("wd_hold%0d", i), 32'(gnt1), 32'h2);
    end
    check("wd_err_pre", 32'(err1), 32'h0);
    tick();
    check("wd_drop", 32'(gnt1), 32'h0);
    check("wd_err", 32'(err1), 32'h1);
    tick();
    check("wd_next", 32'(gnt1), 32'h4);
    req = '0;
    tick();
    tick();
    tick();
    check("wd_sticky", 32'(err1), 32'h1);
`else
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 12; i++) tick();
    check("nowd_hold", 32'(gnt1), 32'h2);
    check("nowd_err", 32'(err1), 32'h0);
`endif

    // Random traffic: one-hot enables and minimum dead gap on both DUTs.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      prev_oe[i] = '0;
      zrun[i]    = 0;
      had[i]     = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      track(0, oe1, 1);
      track(1, oe2, 2);
      req  = 4'($urandom_range(0, 15));
      last = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
